hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, multiply/divide latency in cycles, legal range 2..15.
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have port id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 SHALL have port ex_memread  in  1  EX instruction is a load.
REQ-008 SHALL have port ex_rd  in  5  destination register of the EX instruction.
REQ-009 SHALL have port branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-010 SHALL have port id_jump  in  1  ID instruction is an unconditional jump.
REQ-011 SHALL have port md_start  in  1  ID instruction is a mul/div.
REQ-012 SHALL have port pc_write  out  1  PC register load enable.
REQ-013 SHALL have port ifcon  out  1  IF/ID hold; 1 = keep contents.
REQ-014 SHALL have port flush  out  1  IF/ID clear to zero.
REQ-015 SHALL have port idex_bubble  out  1  ID/EX control fields forced to zero.
REQ-016 SHALL have port md_busy  out  1  high while in MDWAIT.
REQ-017 SHALL have port stall_cnt, flush_cnt  out  CNT_W each  counters of stall cycles and flush cycles.

Function
REQ-018 SHALL implement states RUN and MDWAIT, plus a 4-bit down-counter md_cnt.
REQ-019 SHALL define load_use = ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-020 SHALL generate all outputs combinationally from state and inputs; defaults are pc_write=1, ifcon=0, flush=0, idex_bubble=0.
REQ-021 SHALL apply this priority in RUN: branch_taken > load_use > id_jump > md_start.
REQ-022 In RUN with branch_taken, SHALL assert flush=1 and idex_bubble=1 with pc_write=1, and stay in RUN; the md_start, load_use and id_jump inputs are ignored.
REQ-023 In RUN with load_use and no branch_taken, SHALL assert pc_write=0, ifcon=1 and idex_bubble=1 for exactly that cycle, and stay in RUN.
REQ-024 In RUN with id_jump and no higher-priority condition, SHALL assert flush=1 with pc_write=1 and idex_bubble=0.
REQ-025 In RUN with md_start and no higher-priority condition, SHALL let the mul/div advance with outputs at their defaults, load md_cnt=MD_LAT-2 and enter MDWAIT at the next edge.
REQ-026 In MDWAIT, SHALL hold outputs at pc_write=0, ifcon=1, idex_bubble=1 and md_busy=1, and decrement md_cnt each cycle; when md_cnt==0 it returns to RUN at the next edge, giving MD_LAT-1 stall cycles in total.
REQ-027 In MDWAIT, SHALL ignore branch_taken, id_jump, load_use and md_start; EX holds only bubbles, so these are don't-care.
REQ-028 SHALL increment stall_cnt on every cycle with ifcon=1, and flush_cnt on every cycle with flush=1.
REQ-029 SHALL saturate both counters at all-ones with no wrap.
REQ-030 SHALL keep flush and ifcon mutually exclusive in every cycle.

Reset
REQ-031 While rst=1 at an edge, SHALL set state=RUN, md_cnt=0, stall_cnt=0 and flush_cnt=0.
REQ-032 While rst=1, SHALL drive outputs pc_write=0, ifcon=0, flush=1, idex_bubble=1 and md_busy=0.
REQ-033 Reset asserted mid-MDWAIT SHALL abort the wait; the first cycle after rst deasserts is RUN with default outputs.

Verification
REQ-034 The bench SHALL check load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> for one cycle pc_write=0, ifcon=1, idex_bubble=1; next cycle (ex_memread=0) defaults; stall_cnt=1.
REQ-035 The bench SHALL check ex_rd=0 with a matching id_rs=0 and ex_memread=1 -> no stall.
REQ-036 The bench SHALL check branch_taken=1 with load_use=1 in the same cycle -> flush=1, ifcon=0, pc_write=1, idex_bubble=1; flush_cnt=1, stall_cnt=0.
REQ-037 The bench SHALL check md_start=1 with MD_LAT=4 -> next 3 cycles md_busy=1, ifcon=1, pc_write=0; 4th cycle RUN with defaults; stall_cnt=3.
REQ-038 The bench SHALL check rst=1 on the 2nd MDWAIT cycle -> md_busy=0 and flush=1 during reset; RUN with counters 0 afterwards.
REQ-039 The bench SHALL check saturation with CNT_W=2 and 5 consecutive stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bus: ID/EX hazard inputs and the pipeline
// steering outputs, grouped with the counters they feed.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             branch_taken;
  logic             id_jump;
  logic             md_start;
  logic             pc_write;
  logic             ifcon;
  logic             flush;
  logic             idex_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: drives hazard sources, consumes steering.
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           branch_taken, id_jump, md_start,
    input  pc_write, ifcon, flush, idex_bubble, md_busy, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rd,
           branch_taken, id_jump, md_start,
    output pc_write, ifcon, flush, idex_bubble, md_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, branch/jump flushes and a multi-cycle
// mul/div wait, with saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {S_RUN, S_MDWAIT} state_t;

  state_t           r_state;
  logic [3:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_pc_write;
  logic w_ifcon;
  logic w_flush;
  logic w_idex_bubble;
  logic w_md_busy;
  logic w_md_go;

  // Load-use hazard: EX load writes a nonzero register that ID reads.
  always_comb begin
    w_load_use = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                 ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                  (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));
  end

  // Steering outputs from state and inputs; priority branch > load-use > jump > mul/div.
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifcon       = 1'b0;
    w_flush       = 1'b0;
    w_idex_bubble = 1'b0;
    w_md_busy     = 1'b0;
    w_md_go       = 1'b0;
    if (rst) begin
      w_pc_write    = 1'b0;
      w_flush       = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (r_state == S_MDWAIT) begin
      w_pc_write    = 1'b0;
      w_ifcon       = 1'b1;
      w_idex_bubble = 1'b1;
      w_md_busy     = 1'b1;
    end else if (hz.branch_taken) begin
      w_flush       = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_write    = 1'b0;
      w_ifcon       = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (hz.id_jump) begin
      w_flush       = 1'b1;
    end else if (hz.md_start) begin
      w_md_go       = 1'b1;
    end
  end

  // Mul/div wait FSM: the issue cycle advances, then MD_LAT-1 stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_md_go) begin
            r_state  <= S_MDWAIT;
            r_md_cnt <= 4'(MD_LAT - 2);
          end
        end
        S_MDWAIT: begin
          if (r_md_cnt == 4'd0) r_state <= S_RUN;
          else                  r_md_cnt <= r_md_cnt - 4'd1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_ifcon && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.pc_write    = w_pc_write;
  assign hz.ifcon       = w_ifcon;
  assign hz.flush       = w_flush;
  assign hz.idex_bubble = w_idex_bubble;
  assign hz.md_busy     = w_md_busy;
  assign hz.stall_cnt   = r_stall_cnt;
  assign hz.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: main instance (MD_LAT=4, CNT_W=16) and a
// narrow-counter instance (CNT_W=2) for saturation.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) b1 ();
  hazard_ctrl_if #(.CNT_W(2))  b2 ();

  hazard_ctrl #(.MD_LAT(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(b1));
  hazard_ctrl #(.MD_LAT(4), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .hz(b2));

  // {pc_write, ifcon, flush, idex_bubble, md_busy}
  logic [4:0] o1;
  logic [4:0] o2;
  assign o1 = {b1.pc_write, b1.ifcon, b1.flush, b1.idex_bubble, b1.md_busy};
  assign o2 = {b2.pc_write, b2.ifcon, b2.flush, b2.idex_bubble, b2.md_busy};

  localparam logic [4:0] O_DEF   = 5'b10000;
  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [4:0] O_STALL = 5'b01010;
  localparam logic [4:0] O_BR    = 5'b10110;
  localparam logic [4:0] O_JMP   = 5'b10100;
  localparam logic [4:0] O_MD    = 5'b01011;

  task automatic idle();
    b1.id_rs = '0; b1.id_rt = '0; b1.id_uses_rs = 0; b1.id_uses_rt = 0;
    b1.ex_memread = 0; b1.ex_rd = '0; b1.branch_taken = 0; b1.id_jump = 0; b1.md_start = 0;
    b2.id_rs = '0; b2.id_rt = '0; b2.id_uses_rs = 0; b2.id_uses_rt = 0;
    b2.ex_memread = 0; b2.ex_rd = '0; b2.branch_taken = 0; b2.id_jump = 0; b2.md_start = 0;
  endtask

  // Leaves the bench at a negedge with rst low, state RUN, counters zero.
  task automatic reset_dut();
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle();
    rst = 1;
    #1;
    checks++;
    if (o1 !== O_RST) begin errors++; $display("FAIL reset_outputs: got %b expected %b", o1, O_RST); end
    @(negedge clk);
    checks++;
    if (b1.stall_cnt !== 16'd0 || b1.flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", b1.stall_cnt, b1.flush_cnt);
    end
    rst = 0;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL reset_release: got %b expected %b", o1, O_DEF); end
  endtask

  task automatic test_load_use();
    reset_dut();
    b1.ex_memread = 1; b1.ex_rd = 5'd5; b1.id_rs = 5'd5; b1.id_uses_rs = 1;
    #1;
    checks++;
    if (o1 !== O_STALL) begin errors++; $display("FAIL load_use_rs: got %b expected %b", o1, O_STALL); end
    @(negedge clk);
    b1.ex_memread = 0;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL load_use_next: got %b expected %b", o1, O_DEF); end
    checks++;
    if (b1.stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", b1.stall_cnt); end
    // rt match with rs mismatch also stalls
    b1.ex_memread = 1; b1.ex_rd = 5'd9; b1.id_rs = 5'd3; b1.id_rt = 5'd9; b1.id_uses_rt = 1;
    #1;
    checks++;
    if (o1 !== O_STALL) begin errors++; $display("FAIL load_use_rt: got %b expected %b", o1, O_STALL); end
    // matching register that the instruction does not read: no stall
    b1.id_uses_rt = 0;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL load_use_unused: got %b expected %b", o1, O_DEF); end
  endtask

  task automatic test_rd_zero();
    reset_dut();
    b1.ex_memread = 1; b1.ex_rd = 5'd0; b1.id_rs = 5'd0; b1.id_uses_rs = 1;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL rd_zero: got %b expected %b", o1, O_DEF); end
    @(negedge clk);
    checks++;
    if (b1.stall_cnt !== 16'd0) begin errors++; $display("FAIL rd_zero_cnt: got %0d expected 0", b1.stall_cnt); end
  endtask

  task automatic test_branch_priority();
    reset_dut();
    b1.branch_taken = 1; b1.ex_memread = 1; b1.ex_rd = 5'd7; b1.id_rs = 5'd7; b1.id_uses_rs = 1;
    #1;
    checks++;
    if (o1 !== O_BR) begin errors++; $display("FAIL branch_over_load: got %b expected %b", o1, O_BR); end
    @(negedge clk);
    idle();
    b1.branch_taken = 1; b1.md_start = 1;
    #1;
    checks++;
    if (b1.flush_cnt !== 16'd1 || b1.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_cnts: got %0d/%0d expected 1/0", b1.flush_cnt, b1.stall_cnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL branch_drops_md: got %b expected %b", o1, O_DEF); end
  endtask

  task automatic test_jump();
    reset_dut();
    b1.id_jump = 1; b1.md_start = 1;
    #1;
    checks++;
    if (o1 !== O_JMP) begin errors++; $display("FAIL jump: got %b expected %b", o1, O_JMP); end
    @(negedge clk);
    b1.md_start = 0;
    b1.ex_memread = 1; b1.ex_rd = 5'd4; b1.id_rt = 5'd4; b1.id_uses_rt = 1;
    #1;
    checks++;
    if (o1 !== O_STALL) begin errors++; $display("FAIL load_over_jump: got %b expected %b", o1, O_STALL); end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (b1.flush_cnt !== 16'd1 || b1.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL jump_cnts: got %0d/%0d expected 1/1", b1.flush_cnt, b1.stall_cnt);
    end
  endtask

  task automatic test_mdwait();
    reset_dut();
    b1.md_start = 1;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL md_issue: got %b expected %b", o1, O_DEF); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      b1.branch_taken = 1; b1.id_jump = 1;
      #1;
      checks++;
      if (o1 !== O_MD) begin errors++; $display("FAIL md_wait_%0d: got %b expected %b", i, o1, O_MD); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL md_done: got %b expected %b", o1, O_DEF); end
    checks++;
    if (b1.stall_cnt !== 16'd3 || b1.flush_cnt !== 16'd0) begin
      errors++; $display("FAIL md_cnts: got %0d/%0d expected 3/0", b1.stall_cnt, b1.flush_cnt);
    end
  endtask

  task automatic test_reset_mdwait();
    reset_dut();
    b1.md_start = 1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (o1 !== O_MD) begin errors++; $display("FAIL rmd_wait1: got %b expected %b", o1, O_MD); end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (o1 !== O_RST) begin errors++; $display("FAIL rmd_in_reset: got %b expected %b", o1, O_RST); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL rmd_after: got %b expected %b", o1, O_DEF); end
    checks++;
    if (b1.stall_cnt !== 16'd0 || b1.flush_cnt !== 16'd0) begin
      errors++; $display("FAIL rmd_cnts: got %0d/%0d expected 0/0", b1.stall_cnt, b1.flush_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o1 !== O_DEF) begin errors++; $display("FAIL rmd_stays_run: got %b expected %b", o1, O_DEF); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp;
    reset_dut();
    b2.ex_memread = 1; b2.ex_rd = 5'd12; b2.id_rs = 5'd12; b2.id_uses_rs = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp = (k >= 3) ? 2'd3 : 2'(k);
      #1;
      checks++;
      if (b2.stall_cnt !== exp || o2 !== O_STALL) begin
        errors++; $display("FAIL sat_%0d: got cnt %0d out %b expected cnt %0d out %b", k, b2.stall_cnt, o2, exp, O_STALL);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_priority();
    test_jump();
    test_mdwait();
    test_reset_mdwait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
